ram_arbiter_rr: RTL and testbench

- Parametrised N-port successor to the two-port RAM multiplexer in the core/memory subsystem.
- Arbitrates N_PORTS req/gnt/rvalid master ports (core data, core prog, debug/DMA loaders) onto one single-port synchronous RAM (dataMem/progMem style).
- Arbitration is round-robin instead of fixed priority; data width and address width are generic.
- Returns read data and rvalid only to the port that was granted.

---
 rtl/ram_arbiter_rr_pkg.sv | 25 ++
 rtl/ram_arbiter_rr_pick.sv | 44 ++++
 rtl/ram_arbiter_rr.sv | 161 ++++++++++++++++
 tb/tb_ram_arbiter_rr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_rr_pkg.sv
// Shared definitions for the round-robin RAM arbiter.
// Build option: RAM_ARB_OUTREG_EN registers the RAM command and adds one cycle of response latency.
package ram_arbiter_rr_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned MAX_PORTS      = 8;

`ifdef RAM_ARB_OUTREG_EN
    localparam int unsigned RAM_ARB_LAT = 2;
`else
    localparam int unsigned RAM_ARB_LAT = 1;
`endif

    // Bits needed to encode a port index for n ports (at least 1).
    function automatic int unsigned port_idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin pick: first requester at or above the pointer, wrapping to the lowest requester.
module ram_arbiter_rr_pick
    import ram_arbiter_rr_pkg::*;
#(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned IDX_WIDTH = 3
) (
    input  logic [N_PORTS-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [N_PORTS-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any_req
);

    logic [N_PORTS-1:0]   req_hi;
    logic [N_PORTS-1:0]   sel;
    logic [IDX_WIDTH-1:0] win;

    // Mask off requesters below the pointer; fall back to the full vector to wrap around.
    always_comb begin
        req_hi = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            req_hi[k] = req[k] && (IDX_WIDTH'(k) >= ptr);
        end
        sel = (|req_hi) ? req_hi : req;
    end

    // Lowest-index priority encode of the selected vector, then one-hot grant.
    always_comb begin
        win = '0;
        for (int k = int'(N_PORTS) - 1; k >= 0; k--) begin
            if (sel[k]) begin
                win = IDX_WIDTH'(k);
            end
        end
        any_req = |req;
        idx     = win;
        gnt     = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            gnt[k] = any_req && (win == IDX_WIDTH'(k));
        end
    end

endmodule

// File: rtl/ram_arbiter_rr.sv
// N-port round-robin arbiter onto one single-port synchronous RAM.
// Build option: RAM_ARB_OUTREG_EN registers the RAM command (response latency 2 instead of 1).
module ram_arbiter_rr
    import ram_arbiter_rr_pkg::*;
#(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IDX_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_PORTS-1:0]               port_req_i,
    output logic [N_PORTS-1:0]               port_gnt_o,
    output logic [N_PORTS-1:0]               port_rvalid_o,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]    port_addr_i,
    input  logic [N_PORTS-1:0]               port_we_i,
    input  logic [N_PORTS*DATA_WIDTH/8-1:0]  port_be_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    port_wdata_i,
    output logic [N_PORTS*DATA_WIDTH-1:0]    port_rdata_o,
    output logic                             ram_en_o,
    output logic [ADDR_WIDTH-1:0]            ram_addr_o,
    output logic                             ram_we_o,
    output logic [DATA_WIDTH/8-1:0]          ram_be_o,
    output logic [DATA_WIDTH-1:0]            ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic [N_PORTS-1:0]    gnt_c;
    logic [IDX_WIDTH-1:0]  win_idx;
    logic                  win_any;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_we;
    logic [BE_WIDTH-1:0]   cmd_be;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  vld_s1;
    logic [IDX_WIDTH-1:0]  idx_s1;
    logic                  rsp_vld;
    logic [IDX_WIDTH-1:0]  rsp_idx;

    ram_arbiter_rr_pick #(
        .N_PORTS   (N_PORTS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req     (port_req_i),
        .ptr     (rr_ptr),
        .gnt     (gnt_c),
        .idx     (win_idx),
        .any_req (win_any)
    );

    assign port_gnt_o = gnt_c;

    // Route the winner's command fields; all zero when nobody is granted.
    always_comb begin
        cmd_addr  = '0;
        cmd_we    = 1'b0;
        cmd_be    = '0;
        cmd_wdata = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            if (gnt_c[k]) begin
                cmd_addr  = port_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_we    = port_we_i[k];
                cmd_be    = port_be_i[k*BE_WIDTH +: BE_WIDTH];
                cmd_wdata = port_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pointer moves just past the winner, wrapping explicitly so it never leaves 0..N_PORTS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (win_any) begin
            rr_ptr <= (win_idx == IDX_WIDTH'(N_PORTS - 1)) ? '0 : win_idx + IDX_WIDTH'(1);
        end
    end

    // First response stage: winner index and valid captured in the grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1 <= 1'b0;
            idx_s1 <= '0;
        end else begin
            vld_s1 <= win_any;
            idx_s1 <= win_idx;
        end
    end

`ifdef RAM_ARB_OUTREG_EN
    logic                  ram_en_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic                  ram_we_q;
    logic [BE_WIDTH-1:0]   ram_be_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic                  vld_s2;
    logic [IDX_WIDTH-1:0]  idx_s2;

    // Registered RAM command: the RAM sees the access one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_en_q    <= win_any;
            ram_addr_q  <= cmd_addr;
            ram_we_q    <= cmd_we;
            ram_be_q    <= cmd_be;
            ram_wdata_q <= cmd_wdata;
        end
    end

    // Second response stage tracks the extra command register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s2 <= 1'b0;
            idx_s2 <= '0;
        end else begin
            vld_s2 <= vld_s1;
            idx_s2 <= idx_s1;
        end
    end

    assign ram_en_o    = ram_en_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_we_o    = ram_we_q;
    assign ram_be_o    = ram_be_q;
    assign ram_wdata_o = ram_wdata_q;
    assign rsp_vld     = vld_s2;
    assign rsp_idx     = idx_s2;
`else
    assign ram_en_o    = win_any;
    assign ram_addr_o  = cmd_addr;
    assign ram_we_o    = cmd_we;
    assign ram_be_o    = cmd_be;
    assign ram_wdata_o = cmd_wdata;
    assign rsp_vld     = vld_s1;
    assign rsp_idx     = idx_s1;
`endif

    // Steer RAM read data and valid back to the port that won; everyone else sees zero.
    always_comb begin
        port_rvalid_o = '0;
        port_rdata_o  = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            if (rsp_vld && (rsp_idx == IDX_WIDTH'(k))) begin
                port_rvalid_o[k]                          = 1'b1;
                port_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = ram_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter_rr.sv
// Randomized and directed bench for ram_arbiter_rr against a transaction-level reference model.
module tb_ram_arbiter_rr;
    import ram_arbiter_rr_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int LAT = int'(RAM_ARB_LAT);

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
    } cmd_t;

    typedef struct packed {
        logic          vld;
        logic [1:0]    idx;
        logic [DW-1:0] data;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        port_req_i = '0;
    logic [N-1:0]        port_gnt_o;
    logic [N-1:0]        port_rvalid_o;
    logic [N*AW-1:0]     port_addr_i = '0;
    logic [N-1:0]        port_we_i = '0;
    logic [N*BW-1:0]     port_be_i = '0;
    logic [N*DW-1:0]     port_wdata_i = '0;
    logic [N*DW-1:0]     port_rdata_o;
    logic                ram_en_o;
    logic [AW-1:0]       ram_addr_o;
    logic                ram_we_o;
    logic [BW-1:0]       ram_be_o;
    logic [DW-1:0]       ram_wdata_o;
    logic [DW-1:0]       ram_rdata_i = '0;

    int checks = 0;
    int errors = 0;

    // Requester state and reference model
    logic          act    [N];
    logic [AW-1:0] a_addr [N];
    logic          a_we   [N];
    logic [BW-1:0] a_be   [N];
    logic [DW-1:0] a_wd   [N];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] ram_mem [1024];
    int            ptr_m;
    rsp_t          rsp_q[$];
    cmd_t          prev_cmd;

    ram_arbiter_rr #(
        .N_PORTS    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .port_req_i    (port_req_i),
        .port_gnt_o    (port_gnt_o),
        .port_rvalid_o (port_rvalid_o),
        .port_addr_i   (port_addr_i),
        .port_we_i     (port_we_i),
        .port_be_i     (port_be_i),
        .port_wdata_i  (port_wdata_i),
        .port_rdata_o  (port_rdata_o),
        .ram_en_o      (ram_en_o),
        .ram_addr_o    (ram_addr_o),
        .ram_we_o      (ram_we_o),
        .ram_be_o      (ram_be_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input int unsigned addr, input logic we,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        act[k]    = 1'b1;
        a_addr[k] = AW'(addr);
        a_we[k]   = we;
        a_be[k]   = be;
        a_wd[k]   = wd;
    endtask

    task automatic model_reset();
        ptr_m = 0;
        rsp_q.delete();
        for (int i = 0; i < LAT; i++) rsp_q.push_back(rsp_t'(0));
        prev_cmd = cmd_t'(0);
        for (int k = 0; k < N; k++) act[k] = 1'b0;
    endtask

    // Assert reset asynchronously from the current time, hold across two edges, release at a negedge.
    task automatic do_reset();
        rst_n      = 1'b0;
        port_req_i = '0;
        model_reset();
        #1;
        check_eq("rst_rvalid_async", 128'(port_rvalid_o), 128'(0));
        check_eq("rst_gnt_idle", 128'(port_gnt_o), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rvalid_held", 128'(port_rvalid_o), 128'(0));
        check_eq("rst_rdata", port_rdata_o, 128'(0));
        check_eq("rst_ram_en", 128'(ram_en_o), 128'(0));
        check_eq("rst_ram_addr", 128'(ram_addr_o), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive after posedge, check and advance the model at negedge, then act as the RAM.
    task automatic step();
        int            win;
        int            k;
        cmd_t          cur;
        cmd_t          exp_ram;
        rsp_t          r;
        rsp_t          nr;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rv;
        logic [127:0]  exp_rd;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            port_req_i[p]              = act[p];
            port_addr_i[p*AW +: AW]    = act[p] ? a_addr[p] : AW'($urandom);
            port_we_i[p]               = act[p] ? a_we[p]   : 1'($urandom);
            port_be_i[p*BW +: BW]      = act[p] ? a_be[p]   : BW'($urandom);
            port_wdata_i[p*DW +: DW]   = act[p] ? a_wd[p]   : $urandom;
        end
        @(negedge clk);
        win = -1;
        for (int i = 0; i < N; i++) begin
            k = (ptr_m + i) % N;
            if (win < 0 && act[k]) win = k;
        end
        cur     = cmd_t'(0);
        exp_gnt = '0;
        if (win >= 0) begin
            exp_gnt  = N'(1) << win;
            cur.en   = 1'b1;
            cur.addr = a_addr[win];
            cur.we   = a_we[win];
            cur.be   = a_be[win];
            cur.wd   = a_wd[win];
        end
        exp_ram = (LAT == 2) ? prev_cmd : cur;
        check_eq("gnt", 128'(port_gnt_o), 128'(exp_gnt));
        check_eq("ram_en", 128'(ram_en_o), 128'(exp_ram.en));
        check_eq("ram_addr", 128'(ram_addr_o), 128'(exp_ram.addr));
        check_eq("ram_we", 128'(ram_we_o), 128'(exp_ram.we));
        check_eq("ram_be", 128'(ram_be_o), 128'(exp_ram.be));
        check_eq("ram_wdata", 128'(ram_wdata_o), 128'(exp_ram.wd));

        r      = rsp_q.pop_front();
        exp_rv = r.vld ? (N'(1) << r.idx) : '0;
        exp_rd = r.vld ? (128'(r.data) << (DW * int'(r.idx))) : 128'(0);
        check_eq("rvalid", 128'(port_rvalid_o), 128'(exp_rv));
        check_eq("rdata", port_rdata_o, exp_rd);

        nr = rsp_t'(0);
        if (win >= 0) begin
            nr.vld  = 1'b1;
            nr.idx  = 2'(win);
            nr.data = ref_mem[a_addr[win]];
            if (a_we[win]) begin
                for (int b = 0; b < BW; b++) begin
                    if (a_be[win][b]) ref_mem[a_addr[win]][b*8 +: 8] = a_wd[win][b*8 +: 8];
                end
            end
            ptr_m    = (win + 1) % N;
            act[win] = 1'b0;
        end
        rsp_q.push_back(nr);
        prev_cmd = cur;

        // Behavioural single-port RAM, read-first, data visible for the following cycle.
        if (ram_en_o) begin
            ram_rdata_i = ram_mem[ram_addr_o];
            if (ram_we_o) begin
                for (int b = 0; b < BW; b++) begin
                    if (ram_be_o[b]) ram_mem[ram_addr_o][b*8 +: 8] = ram_wdata_o[b*8 +: 8];
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < 1024; i++) begin
            v          = $urandom;
            ref_mem[i] = v;
            ram_mem[i] = v;
        end
        ref_mem[16] = 32'hDEADBEEF;
        ram_mem[16] = 32'hDEADBEEF;
        ref_mem[5]  = 32'hAAAAAAAA;
        ram_mem[5]  = 32'hAAAAAAAA;

        do_reset();

        // Single read by port 2
        set_req(2, 'h010, 1'b0, 4'hF, 32'h0);
        repeat (3) step();

        // Full contention from reset
        do_reset();
        for (int c = 0; c < 12; c++) begin
            for (int p = 0; p < N; p++) set_req(p, 32 + p, 1'b0, 4'hF, 32'h0);
            step();
        end
        repeat (LAT) step();

        // Partial write then read of the same word
        set_req(1, 5, 1'b1, 4'b0011, 32'h12345678);
        step();
        set_req(3, 5, 1'b0, 4'hF, 32'h0);
        repeat (3) step();

        // Pointer holds across idle cycles
        do_reset();
        set_req(2, 7, 1'b0, 4'hF, 32'h0);
        step();
        repeat (5) step();
        set_req(0, 8, 1'b0, 4'hF, 32'h0);
        set_req(3, 9, 1'b0, 4'hF, 32'h0);
        repeat (4) step();

        // Reset between grant and response
        set_req(0, 16, 1'b0, 4'hF, 32'h0);
        step();
        step();
        set_req(1, 11, 1'b0, 4'hF, 32'h0);
        step();
        do_reset();
        set_req(0, 12, 1'b0, 4'hF, 32'h0);
        set_req(1, 13, 1'b0, 4'hF, 32'h0);
        repeat (4) step();

        // Random traffic over a small address window to create read-after-write hazards
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!act[p] && ($urandom_range(0, 9) < ((c / 50) % 2 == 0 ? 7 : 2))) begin
                    set_req(p, $urandom_range(0, 15), 1'($urandom), BW'($urandom), $urandom);
                end
            end
            step();
        end
        for (int p = 0; p < N; p++) act[p] = 1'b0;
        repeat (LAT + 1) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
